// File: rtl/plab4_net_domain_merge.sv
// ============================================================================
// Module   : plab4_net_domain_merge
// Purpose  : Merges two security-domain lanes, each buffered by a private
//            2-entry FIFO, onto one router input channel. Define
//            PLAB4_NET_DOMAIN_MERGE_TDM_EN for fixed time-slot arbitration;
//            otherwise arbitration is round-robin with a stall lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plab4_net_domain_merge #(
    parameter int p_msg_cnbits = 44,
    parameter int p_msg_dnbits = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_val_d1,
    output logic                    in_rdy_d1,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d1,

    input  logic                    in_val_d2,
    output logic                    in_rdy_d2,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d2,

    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_msg_cnbits-1:0] out_msg_control,
    output logic [p_msg_dnbits-1:0] out_msg_data,
    output logic                    out_domain
);

    logic [1:0]              w_in_val;
    logic [p_msg_cnbits-1:0] w_in_ctl   [2];
    logic [p_msg_dnbits-1:0] w_in_dat   [2];
    logic [p_msg_cnbits-1:0] w_head_ctl [2];
    logic [p_msg_dnbits-1:0] w_head_dat [2];
    logic [1:0]              w_ne;
    logic [1:0]              w_rdy;
    logic [1:0]              w_enq;
    logic [1:0]              w_deq;
    logic                    w_grant;
    logic                    w_xfer;

    assign w_in_val    = {in_val_d2, in_val_d1};
    assign w_in_ctl[0] = in_msg_control_d1;
    assign w_in_ctl[1] = in_msg_control_d2;
    assign w_in_dat[0] = in_msg_data_d1;
    assign w_in_dat[1] = in_msg_data_d2;

    assign w_enq  = w_in_val & w_rdy;
    assign w_deq  = w_xfer ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    // Lane FIFOs: ready comes from the registered count only, so a lane
    // that fills never bypasses, and an empty lane never passes through.
    for (genvar gl = 0; gl < 2; gl++) begin : g_lane
        logic [1:0]              r_cnt;
        logic                    r_wptr;
        logic                    r_rptr;
        logic [p_msg_cnbits-1:0] r_ctl [2];
        logic [p_msg_dnbits-1:0] r_dat [2];

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_cnt  <= 2'd0;
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                if (w_enq[gl]) r_wptr <= ~r_wptr;
                if (w_deq[gl]) r_rptr <= ~r_rptr;
                case ({w_enq[gl], w_deq[gl]})
                    2'b10:   r_cnt <= r_cnt + 2'd1;
                    2'b01:   r_cnt <= r_cnt - 2'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_enq[gl]) begin
                r_ctl[r_wptr] <= w_in_ctl[gl];
                r_dat[r_wptr] <= w_in_dat[gl];
            end
        end

        assign w_ne[gl]       = (r_cnt != 2'd0);
        assign w_rdy[gl]      = reset && (r_cnt != 2'd2);
        assign w_head_ctl[gl] = r_ctl[r_rptr];
        assign w_head_dat[gl] = r_dat[r_rptr];
    end

`ifdef PLAB4_NET_DOMAIN_MERGE_TDM_EN
    // Slot toggles regardless of traffic so neither domain can sense the other.
    logic r_slot;

    always_ff @(posedge clk) begin
        if (!reset) r_slot <= 1'b0;
        else        r_slot <= ~r_slot;
    end

    assign w_grant = r_slot;
`else
    logic r_prio;
    logic r_lock;
    logic r_lock_lane;

    always_comb begin
        w_grant = r_prio;
        if (r_lock)               w_grant = r_lock_lane;
        else if (w_ne == 2'b01)   w_grant = 1'b0;
        else if (w_ne == 2'b10)   w_grant = 1'b1;
    end

    // A stalled offer is locked so the presented message cannot change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prio      <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_lane <= 1'b0;
        end else if (w_xfer) begin
            r_prio      <= ~w_grant;
            r_lock      <= 1'b0;
        end else if (out_val) begin
            r_lock      <= 1'b1;
            r_lock_lane <= w_grant;
        end
    end
`endif

    assign in_rdy_d1       = w_rdy[0];
    assign in_rdy_d2       = w_rdy[1];
    assign out_val         = reset && w_ne[w_grant];
    assign w_xfer          = out_val && out_rdy;
    assign out_domain      = reset && w_grant;
    assign out_msg_control = w_head_ctl[w_grant];
    assign out_msg_data    = w_head_dat[w_grant];

endmodule

`default_nettype wire

// File: doc/plab4_net_domain_merge.md
PLAB4_NET_DOMAIN_MERGE -- requirements
Module: plab4_net_domain_merge

Interface
REQ-001 The module SHALL have parameter p_msg_cnbits, default 44, giving the control-message width in bits (m).
REQ-002 The module SHALL have parameter p_msg_dnbits, default 32, giving the data-payload width in bits (pd).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 The module SHALL have ports in_val_d1 (input, 1), in_rdy_d1 (output, 1), in_msg_control_d1 (input, m) and in_msg_data_d1 (input, pd): the domain-1 lane from the upstream demux.
REQ-006 The module SHALL have ports in_val_d2 (input, 1), in_rdy_d2 (output, 1), in_msg_control_d2 (input, m) and in_msg_data_d2 (input, pd): the domain-2 lane.
REQ-007 The module SHALL have ports out_val (output, 1), out_rdy (input, 1), out_msg_control (output, m) and out_msg_data (output, pd): the merged channel toward a router input.
REQ-008 The module SHALL have port out_domain, output, 1 bit: 0 when the current output message is from d1, 1 when it is from d2.

Function
REQ-009 Each lane SHALL own a private 2-entry FIFO that stores the control and data fields together; no storage is shared between lanes.
REQ-010 Lane enqueue rule: in_rdy_dX = (count_dX < 2); an enqueue occurs when in_val_dX && in_rdy_dX.
REQ-011 A full lane SHALL deassert in_rdy the same cycle it reaches count 2; a dequeue in that cycle SHALL NOT re-raise in_rdy until the next cycle, so there is no full-bypass path.
REQ-012 An empty lane SHALL NOT bypass: a message enqueued in cycle N SHALL appear on the output no earlier than cycle N+1, giving a minimum latency of 1 cycle.
REQ-013 The output signals SHALL be combinational from the granted lane's FIFO head: out_val = nonempty(grant); out_msg_control, out_msg_data and out_domain come from the grant lane.
REQ-014 A dequeue SHALL occur on the grant lane only, when out_val && out_rdy; at most one message transfers per cycle.
REQ-015 Simultaneous enqueue and dequeue on the same lane SHALL leave its count unchanged and advance both pointers.
REQ-016 Pointers SHALL be 1 bit each and wrap from 1 to 0; counts SHALL be 2 bits, saturating at 0..2.
REQ-017 Arbitration (default build) SHALL be round-robin using a 1-bit priority register prio, reset value 0 (d1).
REQ-018 When only one lane is nonempty, grant SHALL select that lane.
REQ-019 When both lanes are nonempty, grant SHALL be prio.
REQ-020 After a successful transfer from lane L, prio SHALL become the other lane.
REQ-021 Stall rule: while out_val && !out_rdy, grant SHALL be held (registered lock), so out_msg and out_domain stay stable until the transfer completes.
REQ-022 When both lanes are empty, out_val=0 and out_domain SHALL equal prio.

Reset
REQ-023 While reset=0 at a clock edge, all FIFO counts and pointers, prio, the lock and the TDM slot SHALL be cleared to 0.
REQ-024 During and after reset: out_val=0, out_domain=0, in_rdy_d1=in_rdy_d2=0 while reset is asserted, and 1 in the first cycle after.
REQ-025 Reset asserted mid-transfer SHALL discard all queued messages; FIFO contents need not be cleared.

Configuration
REQ-026 Macro PLAB4_NET_DOMAIN_MERGE_TDM_EN SHALL select the arbitration mode.
REQ-027 When PLAB4_NET_DOMAIN_MERGE_TDM_EN is defined, grant SHALL equal a 1-bit slot register that toggles every cycle unconditionally (reset 0).
REQ-028 In TDM mode the lock and prio SHALL be unused, and out_val MAY drop while stalled when the slot changes; this makes occupancy of one domain unobservable to the other.
REQ-029 When PLAB4_NET_DOMAIN_MERGE_TDM_EN is undefined, round-robin per REQ-017..REQ-022 SHALL apply.

Verification
REQ-030 Reset scenario: hold reset=0 for 2 cycles -> out_val=0, out_domain=0, in_rdy_d1=in_rdy_d2=0; release -> both in_rdy=1 on the next cycle.
REQ-031 Single-lane scenario: enqueue d1 control=0x5, data=0xA5A5A5A5 with out_rdy=1 -> the next cycle shows out_val=1, out_domain=0 and the same fields; FIFO empty after it.
REQ-032 Fill scenario: out_rdy=0, three back-to-back d2 enqueues -> in_rdy_d2=0 after the second; the third is not accepted; draining yields messages in order.
REQ-033 Round-robin scenario: both lanes hold 2 messages with out_rdy=1 -> out_domain sequence is 0,1,0,1.
REQ-034 Stall scenario: both lanes nonempty, grant=d2, out_rdy=0 for 3 cycles -> out_domain=1 and fields stay constant; with out_rdy=1, d2 transfers, then d1.
REQ-035 TDM scenario: build with PLAB4_NET_DOMAIN_MERGE_TDM_EN, d1 continuously full, d2 empty -> d1 transfers only in even cycles, and out_val=0 in odd cycles.
